// File: rtl/rotsq_pkg.sv
// rotsq_pkg: segment patterns and position-to-pattern map for the rotating square.
//   PAT_UPPER / PAT_LOWER / PAT_BLANK : active-low {dp,g,f,e,d,c,b,a} patterns
//   pos_to_pat(pos, digit, n)         : pattern shown on digit for square position pos
package rotsq_pkg;

    localparam logic [7:0] PAT_UPPER = 8'b1001_1100;
    localparam logic [7:0] PAT_LOWER = 8'b1010_0011;
    localparam logic [7:0] PAT_BLANK = 8'hFF;

    // Upper row walks left to right (digit n-1 first), lower row walks back right to left.
    function automatic logic [7:0] pos_to_pat(input int unsigned pos, input int unsigned digit,
                                              input int unsigned n);
        return (pos < n) ? ((digit == n - 1 - pos) ? PAT_UPPER : PAT_BLANK)
                         : ((digit == pos - n) ? PAT_LOWER : PAT_BLANK);
    endfunction

endpackage

// File: rtl/rotsq_tick.sv
// rotsq_tick: divide-by counter with enable and a run-time limit; registered tick output.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_en         : counter advances while high, holds while low
//   i_limit      : counter clears on reaching (or exceeding) this value
//   o_tick       : one-cycle pulse, the cycle after the counter clears
module rotsq_tick #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;
    logic         r_tick;
    logic         w_hit;

    // >= rather than == so a limit lowered below the current count fires at once.
    assign w_hit  = i_en && (r_cnt >= i_limit);
    assign o_tick = r_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_hit;
            r_cnt  <= w_hit ? '0 : (i_en ? r_cnt + 1'b1 : r_cnt);
        end
    end

endmodule

// File: rtl/rotating_square_mux_n.sv
// rotating_square_mux_n: walks a square around an N-digit seven-segment display and scans the anodes.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : 1 = square advances, 0 = position frozen (scan keeps running)
//   cw           : 1 = clockwise, 0 = counter-clockwise
//   speed        : step rate multiplier 2^speed
//   an           : active-low anode enables, bit 0 = rightmost digit
//   sseg         : active-low segments {dp,g,f,e,d,c,b,a}
//   pos          : current square position 0..2N-1
//   step         : one-cycle pulse per position change
// Optional: define ROTSQ_TRAIL_EN to also light the previous position as a trail.
module rotating_square_mux_n
    import rotsq_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int STEP_DIV = 25_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic                          cw,
    input  logic [1:0]                    speed,
    output logic [N_DIGITS-1:0]           an,
    output logic [7:0]                    sseg,
    output logic [$clog2(2*N_DIGITS)-1:0] pos,
    output logic                          step
);

    localparam int PW  = $clog2(2 * N_DIGITS);
    localparam int SLW = $clog2(N_DIGITS);
    localparam int STW = $clog2(STEP_DIV + 1);
    localparam int SCW = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0]  POS_MAX = PW'(2 * N_DIGITS - 1);
    localparam logic [SLW-1:0] SEL_MAX = SLW'(N_DIGITS - 1);

    if (N_DIGITS < 2 || N_DIGITS > 8 || (STEP_DIV >> 3) < 1 || SCAN_DIV < 1) begin : g_bad_param
        $error("rotating_square_mux_n: illegal parameters");
    end

    logic [31:0]         w_step_div;
    logic [STW-1:0]      w_step_lim;
    logic                w_step;
    logic                w_scan;
    logic [7:0]          w_pat;
    logic [PW-1:0]       r_pos;
    logic [SLW-1:0]      r_sel;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_sseg;

    assign w_step_div = 32'(STEP_DIV) >> speed;
    assign w_step_lim = STW'(w_step_div - 32'd1);

    rotsq_tick #(.W(STW)) u_step (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (en),
        .i_limit (w_step_lim),
        .o_tick  (w_step)
    );

    rotsq_tick #(.W(SCW)) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (1'b1),
        .i_limit (SCW'(SCAN_DIV - 1)),
        .o_tick  (w_scan)
    );

    // cw is sampled while step is high, so a direction change lands on the next step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= '0;
            r_sel <= '0;
        end else begin
            if (w_step)
                r_pos <= cw ? ((r_pos == POS_MAX) ? '0 : r_pos + 1'b1)
                            : ((r_pos == '0) ? POS_MAX : r_pos - 1'b1);
            if (w_scan)
                r_sel <= (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
        end
    end

`ifdef ROTSQ_TRAIL_EN
    logic [PW-1:0] r_trail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_trail <= '0;
        else if (w_step)
            r_trail <= r_pos;
    end

    // AND of active-low patterns lights the union of head and trail segments.
    assign w_pat = pos_to_pat(32'(r_pos), 32'(r_sel), N_DIGITS)
                 & pos_to_pat(32'(r_trail), 32'(r_sel), N_DIGITS);
`else
    assign w_pat = pos_to_pat(32'(r_pos), 32'(r_sel), N_DIGITS);
`endif

    // Anode and segments register together so they never disagree for a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an   <= '1;
            r_sseg <= PAT_BLANK;
        end else begin
            r_an   <= ~(N_DIGITS'(1) << r_sel);
            r_sseg <= w_pat;
        end
    end

    assign an   = r_an;
    assign sseg = r_sseg;
    assign pos  = r_pos;
    assign step = w_step;

endmodule
